// File: rtl/pipe_stage_chain.sv
// Elastic pipeline of DEPTH register stages carrying a WIDTH-bit payload.
// Each stage has a valid bit. A valid/ready chain lets items move into empty
// stages while the stages downstream are stalled (bubble collapsing). A
// front-end flush kills the youngest FLUSH_STAGES stages. The block also
// provides occupancy and retire counters so a bench can observe the pipe.
module pipe_stage_chain #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 5,
  parameter int FLUSH_STAGES = 2,
  parameter int CNT_W        = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  input  logic                           flush,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_data,
  output logic [$clog2(DEPTH+1)-1:0]     occupancy,
  output logic [CNT_W-1:0]               retired_count
);

  localparam int   OCC_W    = $clog2(DEPTH + 1);
  localparam logic FLUSH_EN = (FLUSH_STAGES > 0);

  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [DEPTH-1:0][WIDTH-1:0] data_q,  data_d;
  logic [CNT_W-1:0]            retired_q, retired_d;
  logic [DEPTH:0]              rdy;
  logic [OCC_W-1:0]            occ_d;
  logic                        flush_act;
  logic                        in_hs;
  logic                        out_hs;

  assign flush_act = flush && FLUSH_EN;
  assign in_ready  = rdy[0] && !flush_act;
  assign in_hs     = in_valid && in_ready;
  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign out_hs    = out_valid && out_ready;

  // Ready chain from the output back to stage 0: a stage can load when it is
  // empty or when the stage after it can load.
  always_comb begin
    logic r;
    // NOTE: every variable in a combinational block gets a default before any
    // condition, so no path leaves it unassigned and no latch is inferred.
    rdy        = '0;
    r          = out_ready;
    rdy[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      r      = !valid_q[i] || r;
      rdy[i] = r;
    end
  end

  // Next state of every stage: advance where ready, hold otherwise. Then
  // apply the flush kill on top of that.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;

    // Stage 0 loads from the upstream port. Its data only changes on a real
    // input handshake, so in_data is never captured while in_ready is low.
    if (rdy[0]) begin
      valid_d[0] = in_hs;
    end
    if (in_hs) begin
      data_d[0] = in_data;
    end

    // The data register only moves when a valid item arrives. The contents
    // of an empty stage are not used.
    for (int i = 1; i < DEPTH; i++) begin
      if (rdy[i]) begin
        valid_d[i] = valid_q[i-1];
        if (valid_q[i-1]) begin
          data_d[i] = data_q[i-1];
        end
      end
    end

    // Flush clears the youngest stages. The first surviving stage receives
    // nothing from the killed stage, so it empties if its own item moves on.
    if (flush_act) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i < FLUSH_STAGES) begin
          valid_d[i] = 1'b0;
        end else if (i == FLUSH_STAGES && rdy[i]) begin
          valid_d[i] = 1'b0;
        end
      end
    end
  end

  // Retire counter: one count per output handshake, wraps naturally.
  always_comb begin
    retired_d = retired_q + CNT_W'(out_hs);
  end

  // Occupancy is the population count of the stage valid bits.
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + OCC_W'(valid_q[i]);
    end
  end

  assign occupancy     = occ_d;
  assign retired_count = retired_q;

  // Stage and counter registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= '0;
      // NOTE: the payload registers are reset as well as the valid bits,
      // because out_data must read as zero after reset.
      data_q    <= '0;
      retired_q <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every stage samples the values
      // its neighbours held before this edge.
      valid_q   <= valid_d;
      data_q    <= data_d;
      retired_q <= retired_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Randomised and scenario bench for pipe_stage_chain. Three instances see the
// same stimulus: the default build, a build with flush disabled, and a build
// with a 4-bit retire counter whose flush clears the whole pipe. Each instance
// is compared every cycle against a slot-shifting reference model.
module tb_pipe_stage_chain;

  localparam int D = 5;
  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_data = '0;

  logic        ir   [N];
  logic        ov   [N];
  logic [31:0] od   [N];
  logic [2:0]  occw [N];
  logic [31:0] retw [N];
  logic [3:0]  ret_c;

  assign retw[2] = {28'd0, ret_c};

  pipe_stage_chain #(.WIDTH(32), .DEPTH(D), .FLUSH_STAGES(2), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .flush(flush), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .occupancy(occw[0]), .retired_count(retw[0]));

  pipe_stage_chain #(.WIDTH(32), .DEPTH(D), .FLUSH_STAGES(0), .CNT_W(32)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .flush(flush), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .occupancy(occw[1]), .retired_count(retw[1]));

  pipe_stage_chain #(.WIDTH(32), .DEPTH(D), .FLUSH_STAGES(D), .CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
    .flush(flush), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
    .occupancy(occw[2]), .retired_count(ret_c));

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;

  // Reference model: one slot array per instance.
  int          fs_of   [N] = '{2, 0, D};
  logic [31:0] mask_of [N] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_000F};
  bit          mv   [N][D];
  logic [31:0] md   [N][D];
  int unsigned mcnt [N];

  // Observations of dut_a (and dut_b outputs) for scenario checks.
  int          cyc = 0;
  logic        obs_ir;
  logic        obs_acc;
  logic [2:0]  obs_occ;
  int          obs_cyc;
  logic [31:0] qa[$];
  int          qa_cyc[$];
  logic [31:0] qb[$];

  task automatic clear_model();
    for (int k = 0; k < N; k++) begin
      mcnt[k] = 0;
      for (int i = 0; i < D; i++) begin
        mv[k][i] = 1'b0;
        md[k][i] = '0;
      end
    end
    qa.delete();
    qa_cyc.delete();
    qb.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    #1;
    rst = 1'b0;
    clear_model();
  endtask

  // One clock cycle: drive inputs after the falling edge, compare every
  // instance against the model, then advance the model to the next edge.
  task automatic step(input bit iv, input logic [31:0] id, input bit fl, input bit ordy);
    bit          v [D];
    logic [31:0] d [D];
    bit          ret, fa, erdy;
    int          occ;
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    flush     = fl;
    out_ready = ordy;
    #1;
    for (int k = 0; k < N; k++) begin
      occ = 0;
      for (int i = 0; i < D; i++) begin
        v[i] = mv[k][i];
        d[i] = md[k][i];
        occ += int'(v[i]);
      end

      checks++;
      if (ov[k] !== v[D-1]) begin
        failures++;
        $display("FAIL out_valid dut%0d cyc=%0d got=%b exp=%b", k, cyc, ov[k], v[D-1]);
      end
      if (v[D-1]) begin
        checks++;
        if (od[k] !== d[D-1]) begin
          failures++;
          $display("FAIL out_data dut%0d cyc=%0d got=%0h exp=%0h", k, cyc, od[k], d[D-1]);
        end
      end
      checks++;
      if ({29'd0, occw[k]} !== 32'(occ)) begin
        failures++;
        $display("FAIL occupancy dut%0d cyc=%0d got=%0d exp=%0d", k, cyc, occw[k], occ);
      end
      checks++;
      if (retw[k] !== (mcnt[k] & mask_of[k])) begin
        failures++;
        $display("FAIL retired dut%0d cyc=%0d got=%0d exp=%0d", k, cyc, retw[k], mcnt[k] & mask_of[k]);
      end

      // Oldest slot drains first; each remaining item then slides one slot
      // forward into a free slot, oldest item first.
      ret = v[D-1] && ordy;
      fa  = fl && (fs_of[k] > 0);
      if (ret) v[D-1] = 1'b0;
      if (fa) begin
        for (int i = 0; i < fs_of[k]; i++) v[i] = 1'b0;
      end
      for (int i = D - 2; i >= 0; i--) begin
        if (v[i] && !v[i+1]) begin
          v[i+1] = 1'b1;
          d[i+1] = d[i];
          v[i]   = 1'b0;
        end
      end
      erdy = !v[0] && !fa;

      checks++;
      if (ir[k] !== erdy) begin
        failures++;
        $display("FAIL in_ready dut%0d cyc=%0d got=%b exp=%b", k, cyc, ir[k], erdy);
      end

      if (iv && erdy) begin
        v[0] = 1'b1;
        d[0] = id;
      end
      if (ret) mcnt[k]++;
      for (int i = 0; i < D; i++) begin
        mv[k][i] = v[i];
        md[k][i] = d[i];
      end
    end

    obs_ir  = ir[0];
    obs_acc = iv && ir[0];
    obs_occ = occw[0];
    obs_cyc = cyc;
    if (ov[0] === 1'b1 && ordy) begin
      qa.push_back(od[0]);
      qa_cyc.push_back(cyc);
    end
    if (ov[1] === 1'b1 && ordy) qb.push_back(od[1]);
    cyc++;
  endtask

  task automatic test_reset();
    #2;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (ov[k] !== 1'b0 || od[k] !== 32'd0 || occw[k] !== 3'd0 || retw[k] !== 32'd0 || ir[k] !== 1'b1) begin
        failures++;
        $display("FAIL reset_state dut%0d got ov=%b od=%0h occ=%0d ret=%0d ir=%b exp 0 0 0 0 1",
                 k, ov[k], od[k], occw[k], retw[k], ir[k]);
      end
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    clear_model();
  endtask

  task automatic test_streaming();
    int       c0 = -1;
    logic [2:0] max_occ = '0;
    do_reset();
    for (int v = 1; v <= 10; v++) begin
      step(1'b1, 32'(v), 1'b0, 1'b1);
      if (obs_acc && c0 < 0) c0 = obs_cyc;
      if (obs_occ > max_occ) max_occ = obs_occ;
    end
    repeat (8) begin
      step(1'b0, 32'd0, 1'b0, 1'b1);
      if (obs_occ > max_occ) max_occ = obs_occ;
    end
    checks++;
    if (qa.size() != 10) begin
      failures++;
      $display("FAIL stream_count got=%0d exp=10", qa.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (qa[i] !== 32'(i + 1) || qa_cyc[i] != qa_cyc[0] + i) begin
          failures++;
          $display("FAIL stream_item%0d got=%0d@%0d exp=%0d@%0d", i, qa[i], qa_cyc[i], i + 1, qa_cyc[0] + i);
        end
      end
      checks++;
      if (qa_cyc[0] - c0 != D) begin
        failures++;
        $display("FAIL stream_latency got=%0d exp=%0d", qa_cyc[0] - c0, D);
      end
    end
    checks++;
    if (max_occ !== 3'd5) begin
      failures++;
      $display("FAIL stream_peak_occ got=%0d exp=5", max_occ);
    end
    checks++;
    if (retw[0] !== 32'd10) begin
      failures++;
      $display("FAIL stream_retired got=%0d exp=10", retw[0]);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int v = 1; v <= 5; v++) begin
      step(1'b1, 32'(v), 1'b0, 1'b0);
      checks++;
      if (obs_acc !== 1'b1) begin
        failures++;
        $display("FAIL bp_accept%0d got=%b exp=1", v, obs_acc);
      end
    end
    step(1'b1, 32'd6, 1'b0, 1'b0);
    checks++;
    if (obs_ir !== 1'b0 || obs_occ !== 3'd5) begin
      failures++;
      $display("FAIL bp_full got ir=%b occ=%0d exp ir=0 occ=5", obs_ir, obs_occ);
    end
    step(1'b1, 32'd6, 1'b0, 1'b1);
    checks++;
    if (obs_acc !== 1'b1) begin
      failures++;
      $display("FAIL bp_accept6 got=%b exp=1", obs_acc);
    end
    repeat (8) step(1'b0, 32'd0, 1'b0, 1'b1);
    checks++;
    if (qa.size() != 6) begin
      failures++;
      $display("FAIL bp_count got=%0d exp=6", qa.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (qa[i] !== 32'(i + 1) || qa_cyc[i] != qa_cyc[0] + i) begin
          failures++;
          $display("FAIL bp_item%0d got=%0d@%0d exp=%0d@%0d", i, qa[i], qa_cyc[i], i + 1, qa_cyc[0] + i);
        end
      end
    end
  endtask

  task automatic test_bubble_collapse();
    int acc = 0;
    do_reset();
    for (int p = 0; p < 9; p++) begin
      if (p % 2 == 0) step(1'b1, 32'(11 + p / 2), 1'b0, 1'b0);
      else            step(1'b0, 32'd0, 1'b0, 1'b0);
      if (obs_acc) acc++;
    end
    step(1'b0, 32'd0, 1'b0, 1'b0);
    checks++;
    if (acc != 5 || obs_occ !== 3'd5) begin
      failures++;
      $display("FAIL bubble_fill got acc=%0d occ=%0d exp acc=5 occ=5", acc, obs_occ);
    end
    repeat (8) step(1'b0, 32'd0, 1'b0, 1'b1);
    checks++;
    if (qa.size() != 5 || qa[0] !== 32'd11 || qa[1] !== 32'd12 || qa[2] !== 32'd13 ||
        qa[3] !== 32'd14 || qa[4] !== 32'd15) begin
      failures++;
      $display("FAIL bubble_order got size=%0d first=%0d exp 5 items 11..15", qa.size(),
               (qa.size() > 0) ? qa[0] : 32'd0);
    end
  endtask

  task automatic test_stalled_flush();
    logic [31:0] r0;
    do_reset();
    for (int v = 1; v <= 5; v++) step(1'b1, 32'(v), 1'b0, 1'b0);
    r0 = retw[0];
    step(1'b1, 32'd99, 1'b1, 1'b0);
    checks++;
    if (obs_ir !== 1'b0) begin
      failures++;
      $display("FAIL sflush_in_ready got=%b exp=0", obs_ir);
    end
    step(1'b0, 32'd0, 1'b0, 1'b0);
    checks++;
    if (obs_occ !== 3'd3) begin
      failures++;
      $display("FAIL sflush_occ got=%0d exp=3", obs_occ);
    end
    repeat (8) step(1'b0, 32'd0, 1'b0, 1'b1);
    checks++;
    if (qa.size() != 3 || qa[0] !== 32'd1 || qa[1] !== 32'd2 || qa[2] !== 32'd3) begin
      failures++;
      $display("FAIL sflush_order got size=%0d exp 1,2,3", qa.size());
    end
    checks++;
    if (retw[0] - r0 !== 32'd3) begin
      failures++;
      $display("FAIL sflush_retired got=%0d exp=3", retw[0] - r0);
    end
  endtask

  task automatic test_flowing_flush();
    int fc;
    do_reset();
    step(1'b1, 32'd8, 1'b0, 1'b1);
    step(1'b1, 32'd7, 1'b0, 1'b1);
    step(1'b0, 32'd0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 1'b1, 1'b1);
    fc = obs_cyc;
    repeat (6) step(1'b0, 32'd0, 1'b0, 1'b1);
    checks++;
    if (qa.size() != 1 || qa[0] !== 32'd8 || qa_cyc[0] != fc + 2) begin
      failures++;
      $display("FAIL fflush_out got size=%0d first=%0d@%0d exp 8@%0d", qa.size(),
               (qa.size() > 0) ? qa[0] : 32'd0, (qa_cyc.size() > 0) ? qa_cyc[0] : -1, fc + 2);
    end
    checks++;
    if (qb.size() != 2 || qb[0] !== 32'd8 || qb[1] !== 32'd7) begin
      failures++;
      $display("FAIL fflush_disabled got size=%0d exp 8,7", qb.size());
    end
  endtask

  task automatic test_wrap_and_reset();
    int c;
    do_reset();
    for (int v = 1; v <= 17; v++) step(1'b1, 32'(v), 1'b0, 1'b1);
    repeat (6) step(1'b0, 32'd0, 1'b0, 1'b1);
    checks++;
    if (retw[2] !== 32'd1 || retw[0] !== 32'd17) begin
      failures++;
      $display("FAIL wrap got cnt4=%0d cnt32=%0d exp 1 17", retw[2], retw[0]);
    end
    for (int v = 1; v <= 5; v++) step(1'b1, 32'(100 + v), 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checks++;
    if (occw[0] !== 3'd5) begin
      failures++;
      $display("FAIL areset_prefill got occ=%0d exp=5", occw[0]);
    end
    #1;
    rst = 1'b1;
    #1;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (ov[k] !== 1'b0 || occw[k] !== 3'd0 || retw[k] !== 32'd0 || od[k] !== 32'd0) begin
        failures++;
        $display("FAIL areset dut%0d got ov=%b occ=%0d ret=%0d od=%0h exp all 0",
                 k, ov[k], occw[k], retw[k], od[k]);
      end
    end
    #1;
    rst = 1'b0;
    clear_model();
    step(1'b1, 32'd42, 1'b0, 1'b1);
    c = obs_cyc;
    repeat (7) step(1'b0, 32'd0, 1'b0, 1'b1);
    checks++;
    if (qa.size() != 1 || qa[0] !== 32'd42 || qa_cyc[0] != c + D) begin
      failures++;
      $display("FAIL areset_resume got size=%0d first=%0d@%0d exp 42@%0d", qa.size(),
               (qa.size() > 0) ? qa[0] : 32'd0, (qa_cyc.size() > 0) ? qa_cyc[0] : -1, c + D);
    end
  endtask

  task automatic test_random();
    do_reset();
    repeat (600) begin
      step(($urandom % 4) != 0, $urandom, ($urandom % 10) == 0, ($urandom % 3) != 0);
    end
    repeat (8) step(1'b0, 32'd0, 1'b0, 1'b1);
  endtask

  initial begin
    clear_model();
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble_collapse();
    test_stalled_flush();
    test_flowing_flush();
    test_wrap_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
